// File: rtl/debug_bus_pkg.sv
// Shared types, encodings and word-packing helpers for the DTM <-> debug bus bridge.
package debug_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int OP_W   = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 34;
  localparam int REQ_W  = ADDR_W + DATA_W + OP_W;
  localparam int RESP_W = DATA_W + OP_W;

  localparam logic [1:0] RESP_SUCCESS = 2'd0;
  localparam logic [1:0] RESP_FAILURE = 2'd1;
  localparam logic [1:0] RESP_TIMEOUT = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  // Request word layout is {addr, data, op}, op in the LSBs.
  function automatic logic [REQ_W-1:0] pack_req(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] data,
                                                input logic [OP_W-1:0]   op);
    return {addr, data, op};
  endfunction

  function automatic logic [RESP_W-1:0] pack_resp(input logic [DATA_W-1:0] data,
                                                  input logic [OP_W-1:0]   resp);
    return {data, resp};
  endfunction

endpackage

// File: rtl/debug_bus_bridge_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; push is gated by full,
// so a full FIFO never accepts in the same cycle it is popped.
module debug_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LG2 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH     = 1 << DEPTH_LG2;
  localparam int PTR_W     = (DEPTH_LG2 > 0) ? DEPTH_LG2 : 1;
  localparam int MEM_DEPTH = 1 << PTR_W;
  localparam int CNT_W     = DEPTH_LG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // A depth-1 FIFO keeps both pointers pinned at entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (DEPTH_LG2 == 0) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (DEPTH_LG2 == 0) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/debug_bus_bridge.sv
// Buffered DTM <-> debug bus bridge with one outstanding transaction, a response
// watchdog that synthesises timeout responses, and handshake/timeout counters.
//   state | meaning
//   IDLE  | may issue the head request if the response FIFO has room
//   WAIT  | one request outstanding; watchdog running
//   DRAIN | timeout already reported; swallow the late response
module debug_bus_bridge
  import debug_bus_pkg::*;
#(
  parameter int DEBUG_OP_BITS   = OP_W,
  parameter int DEBUG_ADDR_BITS = ADDR_W,
  parameter int DEBUG_DATA_BITS = DATA_W,
  parameter int REQ_DEPTH_LG2   = 1,
  parameter int RESP_DEPTH_LG2  = 1,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_BITS        = 32
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   dtm_req_valid,
  output logic                                                   dtm_req_ready,
  input  logic [DEBUG_ADDR_BITS+DEBUG_DATA_BITS+DEBUG_OP_BITS-1:0] dtm_req_data,
  output logic                                                   dtm_resp_valid,
  input  logic                                                   dtm_resp_ready,
  output logic [DEBUG_DATA_BITS+DEBUG_OP_BITS-1:0]                 dtm_resp_data,
  output logic                                                   debug_req_valid,
  input  logic                                                   debug_req_ready,
  output logic [DEBUG_ADDR_BITS-1:0]                             debug_req_bits_addr,
  output logic [DEBUG_DATA_BITS-1:0]                             debug_req_bits_data,
  output logic [DEBUG_OP_BITS-1:0]                               debug_req_bits_op,
  input  logic                                                   debug_resp_valid,
  output logic                                                   debug_resp_ready,
  input  logic [DEBUG_DATA_BITS-1:0]                             debug_resp_bits_data,
  input  logic [DEBUG_OP_BITS-1:0]                               debug_resp_bits_resp,
  output logic                                                   busy,
  output logic [CNT_BITS-1:0]                                    req_count,
  output logic [CNT_BITS-1:0]                                    timeout_count
);
  localparam int REQ_BITS  = DEBUG_ADDR_BITS + DEBUG_DATA_BITS + DEBUG_OP_BITS;
  localparam int RESP_BITS = DEBUG_DATA_BITS + DEBUG_OP_BITS;
  localparam int WD_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam bit   WD_EN  = (TIMEOUT_CYCLES != 0);

  state_e                 state, state_next;
  logic                   req_in_ready, req_out_valid, req_full, req_empty;
  logic [REQ_BITS-1:0]    req_out_data;
  logic                   resp_in_ready, resp_out_valid, resp_full, resp_empty;
  logic [RESP_BITS-1:0]   resp_in_data;
  logic                   resp_push, req_fire, timeout_fire;
  logic [WD_W-1:0]        wd;

  debug_sync_fifo #(.WIDTH(REQ_BITS), .DEPTH_LG2(REQ_DEPTH_LG2)) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (dtm_req_valid && !reset),
    .in_ready (req_in_ready),
    .in_data  (dtm_req_data),
    .out_valid(req_out_valid),
    .out_ready(req_fire),
    .out_data (req_out_data),
    .full     (req_full),
    .empty    (req_empty)
  );

  debug_sync_fifo #(.WIDTH(RESP_BITS), .DEPTH_LG2(RESP_DEPTH_LG2)) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (resp_push),
    .in_ready (resp_in_ready),
    .in_data  (resp_in_data),
    .out_valid(resp_out_valid),
    .out_ready(dtm_resp_ready && !reset),
    .out_data (dtm_resp_data),
    .full     (resp_full),
    .empty    (resp_empty)
  );

  assign dtm_req_ready       = req_in_ready && !reset;
  assign dtm_resp_valid      = resp_out_valid && !reset;
  assign debug_req_bits_op   = req_out_data[DEBUG_OP_BITS-1:0];
  assign debug_req_bits_data = req_out_data[DEBUG_OP_BITS +: DEBUG_DATA_BITS];
  assign debug_req_bits_addr = req_out_data[DEBUG_OP_BITS+DEBUG_DATA_BITS +: DEBUG_ADDR_BITS];
  assign resp_in_data = timeout_fire
                        ? {{DEBUG_DATA_BITS{1'b0}}, DEBUG_OP_BITS'(RESP_TIMEOUT)}
                        : {debug_resp_bits_data, debug_resp_bits_resp};
  assign busy = (state != IDLE) || !req_empty || req_full || !resp_empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    debug_req_valid  = 1'b0;
    debug_resp_ready = 1'b0;
    req_fire         = 1'b0;
    resp_push        = 1'b0;
    timeout_fire     = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          // Only issue when the answer is guaranteed a slot in the response FIFO.
          debug_req_valid = req_out_valid && !resp_full;
          if (req_out_valid && !resp_full && debug_req_ready) begin
            req_fire   = 1'b1;
            state_next = WAIT;
          end
        end
        WAIT: begin
          debug_resp_ready = resp_in_ready;
          if (debug_resp_valid && resp_in_ready) begin
            resp_push  = 1'b1;
            state_next = IDLE;
          end else if (WD_EN && (wd == WD_MAX) && !resp_full) begin
            resp_push    = 1'b1;
            timeout_fire = 1'b1;
            state_next   = DRAIN;
          end
        end
        DRAIN: begin
          debug_resp_ready = 1'b1;
          if (debug_resp_valid) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd            <= '0;
      req_count     <= '0;
      timeout_count <= '0;
    end else begin
      if (req_fire) begin
        wd        <= '0;
        req_count <= req_count + CNT_BITS'(1);
      end else if (state == WAIT && wd != WD_MAX) begin
        wd <= wd + WD_W'(1);
      end
      if (timeout_fire) timeout_count <= timeout_count + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_debug_bus_bridge.sv
// Directed bench for debug_bus_bridge: reset, single read, back-to-back,
// watchdog race and timeout, response backpressure, reset mid-transaction.
module tb_debug_bus_bridge;
  import debug_bus_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               dtm_req_valid, dtm_req_ready;
  logic [REQ_W-1:0]   dtm_req_data;
  logic               dtm_resp_valid, dtm_resp_ready;
  logic [RESP_W-1:0]  dtm_resp_data;
  logic               debug_req_valid, debug_req_ready;
  logic [ADDR_W-1:0]  debug_req_bits_addr;
  logic [DATA_W-1:0]  debug_req_bits_data;
  logic [OP_W-1:0]    debug_req_bits_op;
  logic               debug_resp_valid, debug_resp_ready;
  logic [DATA_W-1:0]  debug_resp_bits_data;
  logic [OP_W-1:0]    debug_resp_bits_resp;
  logic               busy;
  logic [31:0]        req_count, timeout_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_bus_bridge #(
    .DEBUG_OP_BITS(2), .DEBUG_ADDR_BITS(5), .DEBUG_DATA_BITS(34),
    .REQ_DEPTH_LG2(1), .RESP_DEPTH_LG2(0), .TIMEOUT_CYCLES(16), .CNT_BITS(32)
  ) dut (
    .clk(clk), .reset(reset),
    .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_data(dtm_req_data),
    .dtm_resp_valid(dtm_resp_valid), .dtm_resp_ready(dtm_resp_ready), .dtm_resp_data(dtm_resp_data),
    .debug_req_valid(debug_req_valid), .debug_req_ready(debug_req_ready),
    .debug_req_bits_addr(debug_req_bits_addr), .debug_req_bits_data(debug_req_bits_data),
    .debug_req_bits_op(debug_req_bits_op),
    .debug_resp_valid(debug_resp_valid), .debug_resp_ready(debug_resp_ready),
    .debug_resp_bits_data(debug_resp_bits_data), .debug_resp_bits_resp(debug_resp_bits_resp),
    .busy(busy), .req_count(req_count), .timeout_count(timeout_count)
  );

  // Stimulus helpers: all are entered and left on a falling edge.
  task automatic dtm_send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [OP_W-1:0] o, output bit ok);
    ok = 1'b0;
    dtm_req_data  = pack_req(a, d, o);
    dtm_req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (dtm_req_ready) begin @(negedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    dtm_req_valid = 1'b0;
  endtask

  task automatic dtm_recv(output logic [RESP_W-1:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    dtm_resp_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (dtm_resp_valid) begin w = dtm_resp_data; @(negedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    dtm_resp_ready = 1'b0;
  endtask

  task automatic debug_take(output logic [REQ_W-1:0] r, output bit ok);
    ok = 1'b0;
    r  = '0;
    debug_req_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (debug_req_valid) begin
        r = {debug_req_bits_addr, debug_req_bits_data, debug_req_bits_op};
        @(negedge clk); ok = 1'b1; break;
      end
      @(negedge clk);
    end
    debug_req_ready = 1'b0;
  endtask

  task automatic debug_give(input logic [DATA_W-1:0] d, input logic [OP_W-1:0] r, output bit ok);
    ok = 1'b0;
    debug_resp_bits_data = d;
    debug_resp_bits_resp = r;
    debug_resp_valid     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (debug_resp_ready) begin @(negedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    debug_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dtm_req_valid = 1'b1; dtm_resp_ready = 1'b1; debug_req_ready = 1'b1; debug_resp_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dtm_req_ready !== 1'b0) begin errors++; $display("FAIL reset_dtm_req_ready: got %b expected 0", dtm_req_ready); end
    checks++; if (dtm_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_dtm_resp_valid: got %b expected 0", dtm_resp_valid); end
    checks++; if (debug_req_valid !== 1'b0) begin errors++; $display("FAIL reset_debug_req_valid: got %b expected 0", debug_req_valid); end
    checks++; if (debug_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_debug_resp_ready: got %b expected 0", debug_resp_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (req_count !== 32'd0) begin errors++; $display("FAIL reset_req_count: got %0d expected 0", req_count); end
    checks++; if (timeout_count !== 32'd0) begin errors++; $display("FAIL reset_timeout_count: got %0d expected 0", timeout_count); end
    dtm_req_valid = 1'b0; dtm_resp_ready = 1'b0; debug_req_ready = 1'b0; debug_resp_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (dtm_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", dtm_req_ready); end
    checks++; if (debug_resp_ready !== 1'b0) begin errors++; $display("FAIL idle_debug_resp_ready: got %b expected 0", debug_resp_ready); end
  endtask

  task automatic test_single_read();
    bit ok0, ok1, ok2, ok3;
    logic [REQ_W-1:0]  rq;
    logic [RESP_W-1:0] rw;
    checks++; if (debug_req_valid !== 1'b0) begin errors++; $display("FAIL single_empty_valid: got %b expected 0", debug_req_valid); end
    dtm_send(5'h10, 34'd0, OP_READ, ok0);
    checks++; if (!ok0) begin errors++; $display("FAIL single_enqueue: handshake %b expected 1", ok0); end
    checks++; if (debug_req_valid !== 1'b1) begin errors++; $display("FAIL single_latency: debug_req_valid %b expected 1", debug_req_valid); end
    checks++; if (debug_req_bits_addr !== 5'h10) begin errors++; $display("FAIL single_addr_out: got %h expected 10", debug_req_bits_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_high: got %b expected 1", busy); end
    fork
      begin debug_take(rq, ok1); repeat (2) @(negedge clk); debug_give(34'h1_2345_6789, RESP_SUCCESS, ok2); end
      dtm_recv(rw, ok3);
    join
    checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL single_handshakes: got %b%b%b expected 111", ok1, ok2, ok3); end
    checks++; if (rq !== pack_req(5'h10, 34'd0, OP_READ)) begin errors++; $display("FAIL single_req: got %h expected %h", rq, pack_req(5'h10, 34'd0, OP_READ)); end
    checks++; if (rw !== {34'h1_2345_6789, 2'd0}) begin errors++; $display("FAIL single_resp: got %h expected %h", rw, {34'h1_2345_6789, 2'd0}); end
    checks++; if (req_count !== 32'd1) begin errors++; $display("FAIL single_req_count: got %0d expected 1", req_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_b, ok_s, ok_t, ok_r;
    logic [REQ_W-1:0]  rq [4];
    logic [RESP_W-1:0] rw [4];
    dtm_send(5'd1, 34'd0, OP_WRITE, ok_a);
    dtm_send(5'd2, 34'd3, OP_WRITE, ok_b);
    checks++; if (!(ok_a && ok_b)) begin errors++; $display("FAIL b2b_first_two: got %b%b expected 11", ok_a, ok_b); end
    checks++; if (dtm_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: dtm_req_ready %b expected 0", dtm_req_ready); end
    repeat (8) @(negedge clk);
    checks++; if (dtm_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full: dtm_req_ready %b expected 0", dtm_req_ready); end
    checks++; if (req_count !== 32'd1) begin errors++; $display("FAIL b2b_no_issue: req_count %0d expected 1", req_count); end
    ok_s = 1'b1; ok_t = 1'b1; ok_r = 1'b1;
    fork
      begin
        bit o;
        dtm_send(5'd3, 34'd6, OP_WRITE, o); ok_s &= o;
        dtm_send(5'd4, 34'd9, OP_WRITE, o); ok_s &= o;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          bit o1, o2;
          debug_take(rq[i], o1);
          repeat (i) @(negedge clk);
          debug_give(34'h2_0000_0000 + 34'(i), 2'(i % 2), o2);
          ok_t &= o1 & o2;
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          bit o;
          dtm_recv(rw[i], o); ok_r &= o;
        end
      end
    join
    checks++; if (!(ok_s && ok_t && ok_r)) begin errors++; $display("FAIL b2b_handshakes: got %b%b%b expected 111", ok_s, ok_t, ok_r); end
    for (int i = 0; i < 4; i++) begin
      logic [REQ_W-1:0]  exp_rq;
      logic [RESP_W-1:0] exp_rw;
      exp_rq = pack_req(5'(i + 1), 34'(3 * i), OP_WRITE);
      exp_rw = {34'h2_0000_0000 + 34'(i), 2'(i % 2)};
      checks++; if (rq[i] !== exp_rq) begin errors++; $display("FAIL b2b_req%0d: got %h expected %h", i, rq[i], exp_rq); end
      checks++; if (rw[i] !== exp_rw) begin errors++; $display("FAIL b2b_resp%0d: got %h expected %h", i, rw[i], exp_rw); end
    end
    checks++; if (req_count !== 32'd5) begin errors++; $display("FAIL b2b_req_count: got %0d expected 5", req_count); end
  endtask

  task automatic test_race();
    bit ok0, ok1, ok2, ok3;
    logic [REQ_W-1:0]  rq;
    logic [RESP_W-1:0] rw;
    dtm_send(5'h0A, 34'd0, OP_READ, ok0);
    debug_take(rq, ok1);
    repeat (16) @(negedge clk);
    debug_give(34'h0_0BAD_F00D, RESP_SUCCESS, ok2);
    dtm_recv(rw, ok3);
    checks++; if (!(ok0 && ok1 && ok2 && ok3)) begin errors++; $display("FAIL race_handshakes: got %b%b%b%b expected 1111", ok0, ok1, ok2, ok3); end
    checks++; if (rw !== {34'h0_0BAD_F00D, 2'd0}) begin errors++; $display("FAIL race_resp: got %h expected %h", rw, {34'h0_0BAD_F00D, 2'd0}); end
    checks++; if (timeout_count !== 32'd0) begin errors++; $display("FAIL race_timeout_count: got %0d expected 0", timeout_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL race_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    bit ok0, ok1, ok2, ok3, ok4, ok5, ok6;
    logic [REQ_W-1:0]  rq;
    logic [RESP_W-1:0] rw;
    dtm_send(5'h03, 34'd0, OP_READ, ok0);
    debug_take(rq, ok1);
    repeat (16) @(negedge clk);
    checks++; if (dtm_resp_valid !== 1'b0) begin errors++; $display("FAIL to_early: dtm_resp_valid %b expected 0", dtm_resp_valid); end
    @(negedge clk);
    checks++; if (dtm_resp_valid !== 1'b1) begin errors++; $display("FAIL to_valid: dtm_resp_valid %b expected 1", dtm_resp_valid); end
    checks++; if (dtm_resp_data !== {34'd0, 2'd2}) begin errors++; $display("FAIL to_word: got %h expected %h", dtm_resp_data, {34'd0, 2'd2}); end
    checks++; if (timeout_count !== 32'd1) begin errors++; $display("FAIL to_count: got %0d expected 1", timeout_count); end
    dtm_resp_ready = 1'b1;
    @(negedge clk);
    dtm_resp_ready = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_drain_busy: got %b expected 1", busy); end
    dtm_send(5'h07, 34'h3_0000_0001, OP_WRITE, ok2);
    checks++; if (debug_req_valid !== 1'b0) begin errors++; $display("FAIL to_drain_no_issue: debug_req_valid %b expected 0", debug_req_valid); end
    repeat (11) @(negedge clk);
    debug_give(34'h1_1111_1111, RESP_SUCCESS, ok3);
    checks++; if (dtm_resp_valid !== 1'b0) begin errors++; $display("FAIL to_late_dropped: dtm_resp_valid %b expected 0", dtm_resp_valid); end
    checks++; if (debug_req_valid !== 1'b1) begin errors++; $display("FAIL to_resume: debug_req_valid %b expected 1", debug_req_valid); end
    fork
      begin debug_take(rq, ok4); @(negedge clk); debug_give(34'h0_0000_CAFE, RESP_SUCCESS, ok5); end
      dtm_recv(rw, ok6);
    join
    checks++; if (!(ok0 && ok1 && ok2 && ok3 && ok4 && ok5 && ok6)) begin errors++; $display("FAIL to_handshakes: got %b%b%b%b%b%b%b expected all 1", ok0, ok1, ok2, ok3, ok4, ok5, ok6); end
    checks++; if (rq !== pack_req(5'h07, 34'h3_0000_0001, OP_WRITE)) begin errors++; $display("FAIL to_next_req: got %h expected %h", rq, pack_req(5'h07, 34'h3_0000_0001, OP_WRITE)); end
    checks++; if (rw !== {34'h0_0000_CAFE, 2'd0}) begin errors++; $display("FAIL to_next_resp: got %h expected %h", rw, {34'h0_0000_CAFE, 2'd0}); end
    checks++; if (timeout_count !== 32'd1) begin errors++; $display("FAIL to_count_final: got %0d expected 1", timeout_count); end
    checks++; if (req_count !== 32'd8) begin errors++; $display("FAIL to_req_count: got %0d expected 8", req_count); end
  endtask

  task automatic test_backpressure();
    bit ok0, ok1, ok2, ok3, ok4, ok5, ok6, ok7;
    logic [REQ_W-1:0]  rq;
    logic [RESP_W-1:0] rw0, rw1;
    dtm_send(5'h08, 34'd0, OP_READ, ok0);
    dtm_send(5'h09, 34'd0, OP_READ, ok1);
    debug_take(rq, ok2);
    debug_give(34'h0_0000_AAAA, RESP_SUCCESS, ok3);
    repeat (5) @(negedge clk);
    checks++; if (debug_req_valid !== 1'b0) begin errors++; $display("FAIL bp_hold: debug_req_valid %b expected 0", debug_req_valid); end
    checks++; if (dtm_resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_valid: got %b expected 1", dtm_resp_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
    checks++; if (req_count !== 32'd9) begin errors++; $display("FAIL bp_req_count: got %0d expected 9", req_count); end
    fork
      begin dtm_recv(rw0, ok4); dtm_recv(rw1, ok5); end
      begin debug_take(rq, ok6); debug_give(34'h0_0000_BBBB, RESP_FAILURE, ok7); end
    join
    checks++; if (!(ok0 && ok1 && ok2 && ok3 && ok4 && ok5 && ok6 && ok7)) begin errors++; $display("FAIL bp_handshakes: some handshake missing (%b%b%b%b%b%b%b%b)", ok0, ok1, ok2, ok3, ok4, ok5, ok6, ok7); end
    checks++; if (rq !== pack_req(5'h09, 34'd0, OP_READ)) begin errors++; $display("FAIL bp_second_req: got %h expected %h", rq, pack_req(5'h09, 34'd0, OP_READ)); end
    checks++; if (rw0 !== {34'h0_0000_AAAA, 2'd0}) begin errors++; $display("FAIL bp_resp0: got %h expected %h", rw0, {34'h0_0000_AAAA, 2'd0}); end
    checks++; if (rw1 !== {34'h0_0000_BBBB, 2'd1}) begin errors++; $display("FAIL bp_resp1: got %h expected %h", rw1, {34'h0_0000_BBBB, 2'd1}); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok0, ok1, ok2;
    logic [REQ_W-1:0] rq;
    bit saw_valid;
    dtm_send(5'h0B, 34'd0, OP_READ, ok0);
    dtm_send(5'h0C, 34'd0, OP_READ, ok1);
    debug_take(rq, ok2);
    checks++; if (!(ok0 && ok1 && ok2 && busy === 1'b1)) begin errors++; $display("FAIL rmw_setup: handshakes %b%b%b busy %b expected 1111", ok0, ok1, ok2, busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (debug_req_valid !== 1'b0 || dtm_resp_valid !== 1'b0) begin errors++; $display("FAIL rmw_valids: debug_req_valid %b dtm_resp_valid %b expected 0 0", debug_req_valid, dtm_resp_valid); end
    checks++; if (dtm_req_ready !== 1'b0 || debug_resp_ready !== 1'b0) begin errors++; $display("FAIL rmw_readies: dtm_req_ready %b debug_resp_ready %b expected 0 0", dtm_req_ready, debug_resp_ready); end
    checks++; if (req_count !== 32'd0 || timeout_count !== 32'd0) begin errors++; $display("FAIL rmw_counters: req %0d timeout %0d expected 0 0", req_count, timeout_count); end
    reset = 1'b0;
    debug_resp_bits_data = 34'h0_DEAD_BEEF;
    debug_resp_bits_resp = RESP_SUCCESS;
    debug_resp_valid = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dtm_resp_valid || debug_req_valid || debug_resp_ready) saw_valid = 1'b1;
    end
    debug_resp_valid = 1'b0;
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rmw_no_traffic: spurious valid/ready %b expected 0", saw_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %b expected 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    dtm_req_valid = 1'b0; dtm_req_data = '0; dtm_resp_ready = 1'b0;
    debug_req_ready = 1'b0; debug_resp_valid = 1'b0;
    debug_resp_bits_data = '0; debug_resp_bits_resp = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_race();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks %0d errors so far", checks, errors);
    $fatal(1, "global time limit reached");
  end

endmodule

// File: doc/debug_bus_bridge.md
Name: debug_bus_bridge

Overview:
- Single-clock, parametrised bridge between the DTM request/response interface and the debug module's debug bus. Replaces direct wiring of dtm_req_*/dtm_resp_* onto debug_req_*/debug_resp_*.
- Adds configurable-depth request and response buffering.
- Allows exactly one in-order outstanding transaction on the debug side.
- Adds a response watchdog that synthesises a timeout response, and transaction/timeout counters for the harness.

Parameters:
- DEBUG_OP_BITS, 2, request op field width and response code width.
- DEBUG_ADDR_BITS, 5, debug bus address width.
- DEBUG_DATA_BITS, 34, debug bus data width.
- REQ_DEPTH_LG2, 1, log2 of request FIFO depth; 0 means depth 1.
- RESP_DEPTH_LG2, 1, log2 of response FIFO depth.
- TIMEOUT_CYCLES, 1024, cycles to wait for a debug response; 0 disables the watchdog.
- CNT_BITS, 32, width of the statistics counters.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- dtm_req_valid  input  1  DTM request valid
- dtm_req_ready  output  1  request FIFO can accept
- dtm_req_data  input  OP+ADDR+DATA  packed {addr, data, op}
- dtm_resp_valid  output  1  response FIFO non-empty
- dtm_resp_ready  input  1  DTM accepts response
- dtm_resp_data  output  DATA+OP  packed {data, resp}
- debug_req_valid  output  1  request to debug module
- debug_req_ready  input  1  debug module accepts
- debug_req_bits_addr  output  ADDR  request address
- debug_req_bits_data  output  DATA  request data
- debug_req_bits_op  output  OP  request op
- debug_resp_valid  input  1  debug module response valid
- debug_resp_ready  output  1  bridge accepts response
- debug_resp_bits_data  input  DATA  response data
- debug_resp_bits_resp  input  OP  response code
- busy  output  1  transaction outstanding or either FIFO non-empty
- req_count  output  CNT_BITS  completed debug-side request handshakes
- timeout_count  output  CNT_BITS  synthesised timeout responses

Behaviour:
- Reset (synchronous, while reset=1):
  - Both FIFOs emptied; state IDLE; watchdog counter 0; req_count and timeout_count 0.
  - dtm_req_ready, dtm_resp_valid, debug_req_valid and debug_resp_ready are forced 0 while reset is high.
  - A reset mid-transaction discards all queued and outstanding traffic with no response.
- Request FIFO:
  - Depth 2^REQ_DEPTH_LG2; dtm_req_ready = !full.
  - Enqueue when dtm_req_valid && dtm_req_ready. Minimum latency from enqueue to debug_req_valid is 1 cycle.
  - Simultaneous enqueue and dequeue when full: not allowed (ready is low). When empty: the entry is not visible until the next cycle.
- State machine:
  - IDLE: debug_req_valid = request FIFO non-empty AND response FIFO not full. On debug_req_valid && debug_req_ready: pop, req_count+1 (wraps), clear watchdog, go to WAIT.
  - WAIT: debug_resp_ready = response FIFO not full. On debug_resp handshake: push {data, resp}, go to IDLE. Otherwise the watchdog increments, saturating at TIMEOUT_CYCLES.
    - If TIMEOUT_CYCLES != 0, watchdog == TIMEOUT_CYCLES and the response FIFO is not full: push {0, RESP_TIMEOUT}, timeout_count+1, go to DRAIN.
    - A real response in the same cycle the watchdog hits the limit wins; no timeout is generated.
  - DRAIN: debug_resp_ready = 1. A late response is consumed and dropped, then go to IDLE. No new request is issued while in DRAIN.
- Response FIFO:
  - Depth 2^RESP_DEPTH_LG2; dtm_resp_valid = !empty.
  - Simultaneous push and pop when full is not allowed; the full condition gates pushes.
  - The FIFO never overflows, because requests are not issued unless space is available.
- Ordering: responses are returned strictly in request order.
- busy = (state != IDLE) || !req_empty || !resp_empty.

Decomposition:
- Package debug_bus_pkg: state enum (IDLE, WAIT, DRAIN); RESP_SUCCESS=0, RESP_FAILURE=1, RESP_TIMEOUT=2; OP_NOP=0, OP_READ=1, OP_WRITE=2; packing helper functions for the request and response words.
- Sub-module debug_sync_fifo:
  - Parameters WIDTH and DEPTH_LG2.
  - Interface: valid/ready in and out, full, empty.
  - Instantiated twice, for requests and for responses.

Test Plan:
- Single read: addr=5'h10, op=1, data=0. Debug module answers after 3 cycles with data=34'h1_2345_6789, resp=0 → dtm_resp_data={34'h1_2345_6789, 2'd0}; req_count=1; busy returns to 0.
- Back-to-back: 4 requests with REQ_DEPTH_LG2=1 and debug_req_ready low for 10 cycles → dtm_req_ready drops after 2 accepts; all 4 responses arrive in order.
- Timeout: TIMEOUT_CYCLES=16, no debug response → after 16 WAIT cycles, response {0, 2'd2} and timeout_count=1. A late response at cycle 30 is dropped, and the next request then completes normally.
- Race: a debug response arrives exactly when the watchdog reaches 16 → the real response is delivered and timeout_count stays 0.
- Backpressure: dtm_resp_ready=0 with RESP_DEPTH_LG2=0 → after one response, debug_req_valid stays 0 with requests still queued. Releasing dtm_resp_ready resumes traffic.
- Reset mid-WAIT → all valids drop on the next cycle; counters read 0; no spurious dtm_resp_valid afterwards.
